// File: rtl/watch_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// watch_scan_ctrl_pkg
//   Shared constants for the debug-watch scan controller: default datapath
//   widths, the scan_state encodings seen on the scan_state port, and the
//   one-hot codes used on src_sel to pick the display source.
// ----------------------------------------------------------------------------
package watch_scan_ctrl_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDR_WIDTH    = 32;
  localparam int REG_NUM_WIDTH = 5;

  // scan_state encodings
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;

  // src_sel one-hot codes
  localparam logic [3:0] SRC_INSTR = 4'b1000;
  localparam logic [3:0] SRC_REG   = 4'b0100;
  localparam logic [3:0] SRC_ALU   = 4'b0010;
  localparam logic [3:0] SRC_MEM   = 4'b0001;

endpackage

// File: rtl/watch_scan_ctrl_tick_gen.sv
// ----------------------------------------------------------------------------
// watch_scan_ctrl_tick_gen
//   Free-running 32-bit divider that produces a one-clk scan tick on each
//   rising edge of the selected divider bit.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   slow_sel  1 = watch cnt[DIV_SLOW], 0 = watch cnt[DIV_FAST]
//   tick      registered one-clk pulse per rising edge of the selected bit
// ----------------------------------------------------------------------------
module watch_scan_ctrl_tick_gen #(
  parameter int DIV_FAST = 24,
  parameter int DIV_SLOW = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic slow_sel,
  output logic tick
);

  logic [31:0] cnt;
  logic        sel_bit;
  logic        prev_bit;
  logic        slow_sel_d;
  logic        sel_switch;

  assign sel_bit    = slow_sel ? cnt[DIV_SLOW] : cnt[DIV_FAST];
  // On the cycle slow_sel changes, prev_bit still belongs to the other
  // divider bit, so any "edge" seen then is bogus and is masked.
  assign sel_switch = slow_sel ^ slow_sel_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      prev_bit   <= 1'b0;
      slow_sel_d <= 1'b0;
      tick       <= 1'b0;
    end else begin
      cnt        <= cnt + 32'd1;
      prev_bit   <= sel_bit;
      slow_sel_d <= slow_sel;
      tick       <= sel_bit & ~prev_bit & ~sel_switch;
    end
  end

endmodule

// File: rtl/watch_scan_ctrl.sv
// ----------------------------------------------------------------------------
// watch_scan_ctrl
//   Sequences the CPU debug-watch path: generates scan ticks, steps the
//   register-watch index and memory-watch address (auto on ticks in RUN, or
//   one step per button press while paused), and registers the selected
//   watch source onto the 7-seg display word.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   slow_sel        tick rate select (1 = slow divider bit)
//   src_sel         one-hot display source: [3] instr [2] reg [1] alu [0] mem
//   pause           level, stops auto-advance
//   step            level button, each rising edge advances once while paused
//   hold            level, freezes disp_data/disp_valid
//   instr_w, reg_w, alu_w, mem_w   watch sources
//   tick            one-clk scan tick
//   reg_watch_num   register-watch index
//   mem_watch_addr  memory-watch address
//   disp_data       registered display word
//   disp_valid      display word came from a valid one-hot selection
//   scan_state      RUN / PAUSE / STEP
// ----------------------------------------------------------------------------
module watch_scan_ctrl
  import watch_scan_ctrl_pkg::*;
#(
  parameter int DIV_FAST   = 24,
  parameter int DIV_SLOW   = 27,
  parameter int REG_NUM    = 32,
  parameter int ADDR_W     = ADDR_WIDTH,
  parameter int DATA_W     = DATA_WIDTH,
  parameter int MEM_STRIDE = 4,
  parameter int MEM_LIMIT  = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       slow_sel,
  input  logic [3:0]                 src_sel,
  input  logic                       pause,
  input  logic                       step,
  input  logic                       hold,
  input  logic [DATA_W-1:0]          instr_w,
  input  logic [DATA_W-1:0]          reg_w,
  input  logic [DATA_W-1:0]          alu_w,
  input  logic [DATA_W-1:0]          mem_w,
  output logic                       tick,
  output logic [$clog2(REG_NUM)-1:0] reg_watch_num,
  output logic [ADDR_W-1:0]          mem_watch_addr,
  output logic [DATA_W-1:0]          disp_data,
  output logic                       disp_valid,
  output logic [1:0]                 scan_state
);

  localparam int REG_W = $clog2(REG_NUM);
  localparam logic [REG_W-1:0] REG_LAST   = REG_W'(REG_NUM - 1);
  localparam logic [ADDR_W:0]  STRIDE_EXT = (ADDR_W+1)'(MEM_STRIDE);
  localparam logic [ADDR_W:0]  LIMIT_EXT  = (ADDR_W+1)'(MEM_LIMIT);

  function automatic logic [REG_W-1:0] next_reg(input logic [REG_W-1:0] n);
    return (n == REG_LAST) ? '0 : n + 1'b1;
  endfunction

  // One extra bit so a+stride cannot overflow before the limit compare.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + STRIDE_EXT;
    return (sum >= LIMIT_EXT) ? '0 : sum[ADDR_W-1:0];
  endfunction

  watch_scan_ctrl_tick_gen #(
    .DIV_FAST (DIV_FAST),
    .DIV_SLOW (DIV_SLOW)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .slow_sel (slow_sel),
    .tick     (tick)
  );

  logic       step_d;
  logic       step_rise;
  logic       advance;
  logic [1:0] state_next;

  // step_d tracks the button in every state, so a press made while running
  // is consumed there and never replays on entering PAUSE.
  assign step_rise = step & ~step_d;

  always_comb begin
    state_next = scan_state;
    advance    = 1'b0;
    case (scan_state)
      ST_RUN: begin
        if (pause)     state_next = ST_PAUSE;
        else if (tick) advance    = 1'b1;
      end
      ST_PAUSE: begin
        if (!pause)         state_next = ST_RUN;
        else if (step_rise) state_next = ST_STEP;
      end
      ST_STEP: begin
        advance    = 1'b1;
        state_next = ST_PAUSE;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_state     <= ST_RUN;
      step_d         <= 1'b0;
      reg_watch_num  <= '0;
      mem_watch_addr <= '0;
    end else begin
      scan_state <= state_next;
      step_d     <= step;
      if (advance) begin
        reg_watch_num  <= next_reg(reg_watch_num);
        mem_watch_addr <= next_addr(mem_watch_addr);
      end
    end
  end

  logic [DATA_W-1:0] sel_data;
  logic              sel_ok;

  // Zero or multi-hot selections fall to the default: blank, not valid.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    case (src_sel)
      SRC_INSTR: begin sel_data = instr_w; sel_ok = 1'b1; end
      SRC_REG:   begin sel_data = reg_w;   sel_ok = 1'b1; end
      SRC_ALU:   begin sel_data = alu_w;   sel_ok = 1'b1; end
      SRC_MEM:   begin sel_data = mem_w;   sel_ok = 1'b1; end
      default:   begin sel_data = '0;      sel_ok = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else if (!hold) begin
      disp_data  <= sel_data;
      disp_valid <= sel_ok;
    end
  end

endmodule

// File: tb/tb_watch_scan_ctrl.sv
module tb_watch_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        slow_sel;
  logic [3:0]  src_sel;
  logic        pause;
  logic        step;
  logic        hold;
  logic [31:0] instr_w;
  logic [31:0] reg_w;
  logic [31:0] alu_w;
  logic [31:0] mem_w;
  logic        tick;
  logic [4:0]  reg_watch_num;
  logic [31:0] mem_watch_addr;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [1:0]  scan_state;

  int checks = 0;
  int errors = 0;
  int e      = 0;   // clock edges since last reset release (equals divider count)

  watch_scan_ctrl #(
    .DIV_FAST   (2),
    .DIV_SLOW   (4),
    .REG_NUM    (32),
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_STRIDE (4),
    .MEM_LIMIT  (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .slow_sel       (slow_sel),
    .src_sel        (src_sel),
    .pause          (pause),
    .step           (step),
    .hold           (hold),
    .instr_w        (instr_w),
    .reg_w          (reg_w),
    .alu_w          (alu_w),
    .mem_w          (mem_w),
    .tick           (tick),
    .reg_watch_num  (reg_watch_num),
    .mem_watch_addr (mem_watch_addr),
    .disp_data      (disp_data),
    .disp_valid     (disp_valid),
    .scan_state     (scan_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) clk1();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tick"},  {31'd0, tick}, 32'd0);
    chk({tag, "_reg"},   {27'd0, reg_watch_num}, 32'd0);
    chk({tag, "_mem"},   mem_watch_addr, 32'd0);
    chk({tag, "_disp"},  disp_data, 32'd0);
    chk({tag, "_valid"}, {31'd0, disp_valid}, 32'd0);
    chk({tag, "_state"}, {30'd0, scan_state}, 32'd0);
  endtask

  int tick_cnt;

  initial begin
    reset = 1'b1; slow_sel = 1'b0; src_sel = 4'b0000; pause = 1'b0;
    step = 1'b0; hold = 1'b0;
    instr_w = '0; reg_w = '0; alu_w = '0; mem_w = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("reset");
    reset = 1'b0;
    e = 0;

    // Fast tick: cnt[2] rises at cnt=4, tick visible after edge 5, period 8
    run_to(4);  chk("tick_e4", {31'd0, tick}, 32'd0);
    run_to(5);  chk("tick_e5", {31'd0, tick}, 32'd1);
    run_to(6);  chk("tick_e6", {31'd0, tick}, 32'd0);
    chk("reg_after1", {27'd0, reg_watch_num}, 32'd1);
    chk("mem_after1", mem_watch_addr, 32'd4);
    run_to(13); chk("tick_e13", {31'd0, tick}, 32'd1);

    // After 4 ticks: reg=4, mem 4,8,12,16->0
    run_to(30);
    chk("reg_after4", {27'd0, reg_watch_num}, 32'd4);
    chk("mem_after4", mem_watch_addr, 32'd0);

    // After 31 ticks reg=31, mem=12; 32nd tick wraps both to 0
    run_to(246);
    chk("reg_after31", {27'd0, reg_watch_num}, 32'd31);
    chk("mem_after31", mem_watch_addr, 32'd12);
    run_to(254);
    chk("reg_wrap", {27'd0, reg_watch_num}, 32'd0);
    chk("mem_wrap", mem_watch_addr, 32'd0);

    // Pause: 20 ticks ignored
    pause = 1'b1;
    clk1();
    chk("state_pause", {30'd0, scan_state}, 32'd1);
    tick_cnt = 0;
    while (e < 254 + 160) begin
      clk1();
      if (tick) tick_cnt++;
    end
    chk("pause_ticks_seen", tick_cnt, 32'd20);
    chk("pause_reg", {27'd0, reg_watch_num}, 32'd0);
    chk("pause_mem", mem_watch_addr, 32'd0);

    // Three step presses -> three advances
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      clk1();
      chk("state_step", {30'd0, scan_state}, 32'd2);
      clk1();
      chk("state_back_pause", {30'd0, scan_state}, 32'd1);
      chk("step_reg", {27'd0, reg_watch_num}, i + 1);
      step = 1'b0;
      clk1(); clk1();
    end
    chk("step3_reg", {27'd0, reg_watch_num}, 32'd3);
    chk("step3_mem", mem_watch_addr, 32'd12);

    // Step held 50 clocks -> one advance only (mem 12+4=16 wraps to 0)
    step = 1'b1;
    repeat (50) clk1();
    step = 1'b0;
    clk1();
    chk("hold_step_reg", {27'd0, reg_watch_num}, 32'd4);
    chk("hold_step_mem", mem_watch_addr, 32'd0);

    // Display: register source, 1-clk latency
    src_sel = 4'b0100; reg_w = 32'hDEADBEEF;
    chk("disp_before", disp_data, 32'd0);
    clk1();
    chk("disp_reg", disp_data, 32'hDEADBEEF);
    chk("valid_reg", {31'd0, disp_valid}, 32'd1);
    src_sel = 4'b0110;
    clk1();
    chk("disp_multi", disp_data, 32'd0);
    chk("valid_multi", {31'd0, disp_valid}, 32'd0);
    src_sel = 4'b0010; alu_w = 32'h12345678;
    clk1();
    chk("disp_alu", disp_data, 32'h12345678);
    chk("valid_alu", {31'd0, disp_valid}, 32'd1);
    src_sel = 4'b0001; mem_w = 32'h0000A5A5;
    clk1();
    chk("disp_mem", disp_data, 32'h0000A5A5);

    // Hold freezes display
    src_sel = 4'b0010;
    clk1();
    hold = 1'b1;
    alu_w = 32'hCAFEF00D; src_sel = 4'b1000; instr_w = 32'h0BADC0DE;
    clk1(); clk1(); clk1();
    chk("disp_hold", disp_data, 32'h12345678);
    chk("valid_hold", {31'd0, disp_valid}, 32'd1);
    hold = 1'b0;
    clk1();
    chk("disp_unhold", disp_data, 32'h0BADC0DE);
    src_sel = 4'b0000;
    clk1();
    chk("valid_zero_sel", {31'd0, disp_valid}, 32'd0);

    // Switch to slow tick on cycle cnt=20 mod 32: cnt[4]=1 while prev fast bit=0
    while ((e % 32) != 20) clk1();
    slow_sel = 1'b1;
    clk1();
    chk("tick_switch_suppressed", {31'd0, tick}, 32'd0);
    while ((e % 32) != 16) clk1();
    chk("slow_tick_pre", {31'd0, tick}, 32'd0);
    clk1();
    chk("slow_tick_1", {31'd0, tick}, 32'd1);
    tick_cnt = 0;
    repeat (31) begin
      clk1();
      if (tick) tick_cnt++;
    end
    chk("slow_no_extra", tick_cnt, 32'd0);
    clk1();
    chk("slow_tick_2", {31'd0, tick}, 32'd1);

    // Reset mid-STEP
    src_sel = 4'b0100; reg_w = 32'h00000077;
    clk1();
    step = 1'b1;
    clk1();
    chk("pre_reset_state", {30'd0, scan_state}, 32'd2);
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    step = 1'b0; pause = 1'b0; slow_sel = 1'b0; src_sel = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b0;
    e = 0;
    run_to(6);
    chk("resume_reg", {27'd0, reg_watch_num}, 32'd1);
    chk("resume_mem", mem_watch_addr, 32'd4);
    chk("resume_state", {30'd0, scan_state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
